// File: rtl/ipif_pkg.sv
// Shared definitions for the bus-side IPIF register path: AXI response codes,
// register index sizing and the read/write channel FSM states.
package ipif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Index field is at least one bit wide so a single-register file still decodes.
    function automatic int unsigned reg_idx_bits(input int unsigned n_reg);
        return (n_reg <= 1) ? 1 : $clog2(n_reg);
    endfunction

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

endpackage

// File: rtl/ipif_axil_wr_ctrl.sv
// AXI4-Lite write channel controller: latches AW and W independently, checks the
// address range and issues a single-cycle apply command plus the B response.
module ipif_axil_wr_ctrl
    import ipif_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 8,
    parameter int unsigned N_REG = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [AW-1:0]                    awaddr_i,
    input  logic                             awvalid_i,
    output logic                             awready_o,
    input  logic [DW-1:0]                    wdata_i,
    input  logic [DW/8-1:0]                  wstrb_i,
    input  logic                             wvalid_i,
    output logic                             wready_o,
    output logic [1:0]                       bresp_o,
    output logic                             bvalid_o,
    input  logic                             bready_i,
    output logic                             wr_en_o,
    output logic [reg_idx_bits(N_REG)-1:0]   wr_idx_o,
    output logic [DW-1:0]                    wr_data_o,
    output logic [DW/8-1:0]                  wr_strb_o
);

    localparam int unsigned ADDR_LSB = $clog2(DW / 8);
    localparam int unsigned IW       = reg_idx_bits(N_REG);
    localparam logic [AW:0] RANGE_LIMIT = (AW + 1)'(N_REG * (DW / 8));

    wr_state_e       state_q, state_d;
    logic            aw_lat_q, aw_lat_d;
    logic            w_lat_q, w_lat_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW/8-1:0] strb_q, strb_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            aw_hs, w_hs, in_range;

    always_comb begin
        aw_hs    = awvalid_i & awready_q;
        w_hs     = wvalid_i & wready_q;
        // Bypass the holding registers so a handshake can commit on its own edge.
        addr_d   = aw_hs ? awaddr_i : addr_q;
        data_d   = w_hs ? wdata_i : data_q;
        strb_d   = w_hs ? wstrb_i : strb_q;
        in_range = {1'b0, addr_d} < RANGE_LIMIT;

        state_d   = state_q;
        aw_lat_d  = aw_lat_q;
        w_lat_d   = w_lat_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en_o   = 1'b0;
        wr_idx_o  = addr_d[ADDR_LSB +: IW];
        wr_data_o = data_d;
        wr_strb_o = strb_d;

        unique case (state_q)
            W_IDLE: begin
                aw_lat_d = aw_lat_q | aw_hs;
                w_lat_d  = w_lat_q | w_hs;
                if (aw_lat_d && w_lat_d) begin
                    aw_lat_d = 1'b0;
                    w_lat_d  = 1'b0;
                    state_d  = W_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
                    wr_en_o  = in_range;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    state_d  = W_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: state_d = W_IDLE;
        endcase

        awready_d = (state_d == W_IDLE) && !aw_lat_d;
        wready_d  = (state_d == W_IDLE) && !w_lat_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= W_IDLE;
            aw_lat_q  <= 1'b0;
            w_lat_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            aw_lat_q  <= aw_lat_d;
            w_lat_q   <= w_lat_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

endmodule

// File: rtl/ipif_axil_regfile.sv
// AXI4-Lite register file on the bus clock: writes land in params_from_bus,
// reads return the IP-side image params_to_bus.
module ipif_axil_regfile
    import ipif_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned N_REG              = 2,
    parameter logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_from_bus,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] params_to_bus,
    output logic [N_REG-1:0]                    reg_wr_pulse
);

    localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned ADDR_LSB = $clog2(DW / 8);
    localparam int unsigned IW       = reg_idx_bits(N_REG);
    localparam logic [AW:0] RANGE_LIMIT = (AW + 1)'(N_REG * (DW / 8));

    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;

    logic [N_REG*DW-1:0] params_q, params_d;
    logic [N_REG-1:0]    pulse_q, pulse_d;

    ipif_axil_wr_ctrl #(
        .DW    (DW),
        .AW    (AW),
        .N_REG (N_REG)
    ) u_wr_ctrl (
        .clk_i     (S_AXI_ACLK),
        .rst_ni    (S_AXI_ARESETN),
        .awaddr_i  (S_AXI_AWADDR),
        .awvalid_i (S_AXI_AWVALID),
        .awready_o (S_AXI_AWREADY),
        .wdata_i   (S_AXI_WDATA),
        .wstrb_i   (S_AXI_WSTRB),
        .wvalid_i  (S_AXI_WVALID),
        .wready_o  (S_AXI_WREADY),
        .bresp_o   (S_AXI_BRESP),
        .bvalid_o  (S_AXI_BVALID),
        .bready_i  (S_AXI_BREADY),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb)
    );

    always_comb begin
        params_d = params_q;
        pulse_d  = '0;
        for (int i = 0; i < int'(N_REG); i++) begin
            if (wr_en && (wr_idx == IW'(i))) begin
                pulse_d[i] = 1'b1;
                for (int b = 0; b < int'(DW / 8); b++) begin
                    if (wr_strb[b]) begin
                        params_d[i*DW + b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            params_q <= RESET_VALUE;
            pulse_q  <= '0;
        end else begin
            params_q <= params_d;
            pulse_q  <= pulse_d;
        end
    end

    assign params_from_bus = params_q;
    assign reg_wr_pulse    = pulse_q;

    rd_state_e     rd_state_q, rd_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [IW-1:0] ar_idx;
    logic [DW-1:0] ar_sel;
    logic          ar_in_range;

    always_comb begin
        ar_idx      = S_AXI_ARADDR[ADDR_LSB +: IW];
        ar_in_range = {1'b0, S_AXI_ARADDR} < RANGE_LIMIT;
        ar_sel      = '0;
        for (int i = 0; i < int'(N_REG); i++) begin
            if (ar_idx == IW'(i)) begin
                ar_sel = params_to_bus[i*DW +: DW];
            end
        end

        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        unique case (rd_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && arready_q) begin
                    rd_state_d = R_DATA;
                    rvalid_d   = 1'b1;
                    rdata_d    = ar_in_range ? ar_sel : '0;
                    rresp_d    = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                    rvalid_d   = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        arready_d = (rd_state_d == R_IDLE);
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule
